fix_mul_sched: RTL and testbench

Round-robin scheduler that shares one pipelined fixed-point sign-magnitude multiplier (1 sign, 6 integer, 8 fraction bits) between NREQ requesters. Per requester it accepts operand pairs over a valid/ready handshake and drives the shared multiplier. It tags each operation through the multiplier's fixed latency, then renormalises the 29-bit product back to the 15-bit operand format with saturation. Results are queued in a credit-protected response FIFO, so back-pressure never drops a product.

---
 rtl/fix_mul_sched.sv | 148 ++++++++++++++
 tb/tb_fix_mul_sched.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fix_mul_sched.sv
// Round-robin scheduler sharing one pipelined sign-magnitude fixed-point
// multiplier between NREQ requesters. Products are renormalised back to the
// operand format with saturation and queued in a credit-protected FIFO.
module fix_mul_sched #(
  parameter int unsigned DATA       = 15,
  parameter int unsigned POIN       = 8,
  parameter int unsigned NREQ       = 4,
  parameter int unsigned MUL_LAT    = 2,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ*DATA-1:0]      req_a,
  input  logic [NREQ*DATA-1:0]      req_b,
  output logic [NREQ-1:0]           req_ready,
  output logic [DATA-1:0]           mul_a,
  output logic [DATA-1:0]           mul_b,
  output logic                      mul_vld,
  input  logic [2*DATA-2:0]         mul_p,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [$clog2(NREQ)-1:0]   rsp_id,
  output logic [DATA-1:0]           rsp_data,
  output logic                      rsp_ovf,
  output logic                      busy
);

  localparam int unsigned IW = $clog2(NREQ);
  localparam int unsigned MW = 2*DATA-2;
  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH+1);

  typedef struct packed {
    logic [IW-1:0]   id;
    logic [DATA-1:0] data;
    logic            ovf;
  } rsp_t;

  logic [DATA-1:0] op_a [NREQ];
  logic [DATA-1:0] op_b [NREQ];

  logic [IW-1:0]   ptr;
  logic [IW-1:0]   win;
  logic [IW-1:0]   idx;
  logic            found;
  logic            hs;
  logic [CW-1:0]   cred;

  logic [IW-1:0]   mul_id;
  logic [MUL_LAT-1:0] tag_vld;
  logic [IW-1:0]   tag_id [MUL_LAT];

  logic [MW-1:0]   mag;
  logic            sat;
  logic [DATA-2:0] res_mag;
  logic            wr;
  logic            pop;
  rsp_t            wentry;
  rsp_t            head;
  rsp_t            mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   cnt;

  // Split the packed request buses into per-requester operands
  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign op_a[g] = req_a[g*DATA +: DATA];
    assign op_b[g] = req_b[g*DATA +: DATA];
  end

  // Round-robin search: first valid requester at or after the pointer
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = IW'((32'(ptr) + 32'(k)) % NREQ);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign hs        = found && (cred != '0);
  assign req_ready = hs ? (NREQ'(1) << win) : '0;

  // Renormalise the product magnitude with saturation; no negative zero
  always_comb begin
    mag         = mul_p[MW-1:0];
    sat         = |mag[MW-1:POIN+DATA-1];
    res_mag     = sat ? '1 : mag[POIN+DATA-2:POIN];
    wentry.id   = tag_id[MUL_LAT-1];
    wentry.data = {mul_p[MW] & (|res_mag), res_mag};
    wentry.ovf  = sat;
  end

  assign wr        = tag_vld[MUL_LAT-1];
  assign rsp_valid = (cnt != '0);
  assign pop       = rsp_valid && rsp_ready;
  assign head      = rsp_valid ? mem[rd_ptr] : '0;
  assign rsp_id    = head.id;
  assign rsp_data  = head.data;
  assign rsp_ovf   = head.ovf;
  assign busy      = (|tag_vld) || rsp_valid || mul_vld;

  // Issue register, arbitration pointer, credits, tag pipeline and FIFO pointers
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr     <= '0;
      cred    <= CW'(FIFO_DEPTH);
      mul_vld <= 1'b0;
      mul_a   <= '0;
      mul_b   <= '0;
      mul_id  <= '0;
      tag_vld <= '0;
      for (int s = 0; s < MUL_LAT; s++) tag_id[s] <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cnt     <= '0;
    end else begin
      mul_vld <= hs;
      if (hs) begin
        mul_a  <= op_a[win];
        mul_b  <= op_b[win];
        mul_id <= win;
        ptr    <= (win == IW'(NREQ-1)) ? '0 : win + IW'(1);
      end
      cred       <= cred + CW'(pop) - CW'(hs);
      tag_vld[0] <= mul_vld;
      tag_id[0]  <= mul_id;
      for (int s = 1; s < MUL_LAT; s++) begin
        tag_vld[s] <= tag_vld[s-1];
        tag_id[s]  <= tag_id[s-1];
      end
      if (wr)  wr_ptr <= (wr_ptr == AW'(FIFO_DEPTH-1)) ? '0 : wr_ptr + AW'(1);
      if (pop) rd_ptr <= (rd_ptr == AW'(FIFO_DEPTH-1)) ? '0 : rd_ptr + AW'(1);
      cnt <= cnt + CW'(wr) - CW'(pop);
    end
  end

  // Response storage; contents need no reset since the count gates the head
  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= wentry;
  end

endmodule

// File: tb/tb_fix_mul_sched.sv
// Testbench for fix_mul_sched: behavioural multiplier, per-cycle reference
// model of arbitration/credits/response order, table vectors and corner cases.
module tb_fix_mul_sched;

  localparam int unsigned DATA       = 15;
  localparam int unsigned POIN       = 8;
  localparam int unsigned NREQ       = 4;
  localparam int unsigned MUL_LAT    = 2;
  localparam int unsigned FIFO_DEPTH = 8;
  localparam int unsigned IW         = $clog2(NREQ);

  logic                 clk;
  logic                 rst;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*DATA-1:0] req_a;
  logic [NREQ*DATA-1:0] req_b;
  logic [NREQ-1:0]      req_ready;
  logic [DATA-1:0]      mul_a;
  logic [DATA-1:0]      mul_b;
  logic                 mul_vld;
  logic [2*DATA-2:0]    mul_p;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [IW-1:0]        rsp_id;
  logic [DATA-1:0]      rsp_data;
  logic                 rsp_ovf;
  logic                 busy;

  logic [DATA-1:0] op_a [NREQ];
  logic [DATA-1:0] op_b [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_pack
    assign req_a[g*DATA +: DATA] = op_a[g];
    assign req_b[g*DATA +: DATA] = op_b[g];
  end

  fix_mul_sched #(
    .DATA(DATA), .POIN(POIN), .NREQ(NREQ), .MUL_LAT(MUL_LAT), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .mul_a(mul_a), .mul_b(mul_b), .mul_vld(mul_vld), .mul_p(mul_p),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_ovf(rsp_ovf), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared multiplier: sign-magnitude product, MUL_LAT register stages
  logic [2*DATA-2:0] mp [MUL_LAT];
  always @(posedge clk) begin
    mp[0] <= {mul_a[DATA-1] ^ mul_b[DATA-1],
              (2*DATA-2)'(mul_a[DATA-2:0]) * (2*DATA-2)'(mul_b[DATA-2:0])};
    for (int s = 1; s < MUL_LAT; s++) mp[s] <= mp[s-1];
  end
  assign mul_p = mp[MUL_LAT-1];

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference result as {ovf, sign, magnitude}, from real-valued arithmetic
  function automatic logic [DATA:0] ref_op(input logic [DATA-1:0] a, input logic [DATA-1:0] b);
    longint unsigned prod;
    longint unsigned q;
    logic ovf;
    logic neg;
    logic [DATA-2:0] m;
    prod = 64'(a[DATA-2:0]) * 64'(b[DATA-2:0]);
    q    = prod / (64'(1) << POIN);
    ovf  = q > ((64'(1) << (DATA-1)) - 64'(1));
    m    = ovf ? '1 : (DATA-1)'(q);
    neg  = (a[DATA-1] ^ b[DATA-1]) && (m != '0);
    return {ovf, neg, m};
  endfunction

  function automatic logic [DATA-1:0] rnd_op();
    logic [DATA-2:0] m;
    m = (DATA-1)'($urandom) >> $urandom_range(0, 10);
    return {1'($urandom), m};
  endfunction

  // Reference model: every issued op is a queue entry until popped
  typedef struct {
    int              vis;
    logic [IW-1:0]   id;
    logic [DATA:0]   res;
  } exp_t;

  exp_t            q[$];
  int              m_cred = 0;
  int              m_ptr  = 0;
  int              cyc    = 0;
  bit              model_on = 1'b0;
  bit              m_prev_hs = 1'b0;
  logic [DATA-1:0] m_prev_a;
  logic [DATA-1:0] m_prev_b;

  always @(negedge clk) begin : model
    int win;
    int idx;
    logic [NREQ-1:0] er;
    bit ev;
    bit pop;
    exp_t e;
    if (model_on) begin
      win = -1;
      if (m_cred > 0) begin
        for (int k = 0; k < NREQ; k++) begin
          idx = (m_ptr + k) % NREQ;
          if (win < 0 && req_valid[idx]) win = idx;
        end
      end
      er = '0;
      if (win >= 0) er[win] = 1'b1;
      chk("req_ready", 32'(req_ready), 32'(er));
      chk("mul_vld", 32'(mul_vld), 32'(m_prev_hs));
      if (m_prev_hs) begin
        chk("mul_a", 32'(mul_a), 32'(m_prev_a));
        chk("mul_b", 32'(mul_b), 32'(m_prev_b));
      end
      ev = (q.size() > 0) && (q[0].vis <= cyc);
      chk("rsp_valid", 32'(rsp_valid), 32'(ev));
      if (ev) begin
        chk("rsp_id", 32'(rsp_id), 32'(q[0].id));
        chk("rsp_data", 32'(rsp_data), 32'(q[0].res[DATA-1:0]));
        chk("rsp_ovf", 32'(rsp_ovf), 32'(q[0].res[DATA]));
      end
      chk("busy", 32'(busy), 32'(q.size() != 0));
      pop = ev && rsp_ready;
      if (rst) begin
        q.delete();
        m_cred    = int'(FIFO_DEPTH);
        m_ptr     = 0;
        m_prev_hs = 1'b0;
      end else begin
        if (pop) begin
          void'(q.pop_front());
          m_cred++;
        end
        m_prev_hs = (win >= 0);
        if (win >= 0) begin
          e.vis = cyc + 2 + int'(MUL_LAT);
          e.id  = IW'(win);
          e.res = ref_op(op_a[win], op_b[win]);
          q.push_back(e);
          m_cred--;
          m_ptr    = (win + 1) % NREQ;
          m_prev_a = op_a[win];
          m_prev_b = op_b[win];
        end
      end
    end else if (rst) begin
      q.delete();
      m_cred    = int'(FIFO_DEPTH);
      m_ptr     = 0;
      m_prev_hs = 1'b0;
      model_on  = 1'b1;
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    tick();
    rst       = 1'b1;
    req_valid = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    rsp_ready = 1'b1;
    req_valid = '0;
    do begin
      tick();
      @(negedge clk);
      n++;
    end while (busy && n < 60);
    chk(nm, 32'(busy), 32'(0));
  endtask

  // One isolated request: handshake, exact latency, fields, busy after pop
  task automatic single_op(input int id, input logic [DATA-1:0] a, input logic [DATA-1:0] b,
                           input logic [DATA-1:0] d, input logic ovf);
    int lat;
    bit got;
    tick();
    rsp_ready     = 1'b1;
    req_valid     = '0;
    op_a[id]      = a;
    op_b[id]      = b;
    req_valid[id] = 1'b1;
    @(negedge clk);
    chk("single_hs", 32'(req_ready[id]), 32'(1));
    lat = 0;
    got = 1'b0;
    for (int n = 1; n <= 20 && !got; n++) begin
      tick();
      if (n == 1) req_valid = '0;
      @(negedge clk);
      if (rsp_valid) begin
        got = 1'b1;
        lat = n;
      end
    end
    chk("single_latency", 32'(lat), 32'(2 + MUL_LAT));
    chk("single_id", 32'(rsp_id), 32'(id));
    chk("single_data", 32'(rsp_data), 32'(d));
    chk("single_ovf", 32'(rsp_ovf), 32'(ovf));
    tick();
    @(negedge clk);
    chk("single_busy_after_pop", 32'(busy), 32'(0));
  endtask

  typedef struct {
    int              id;
    logic [DATA-1:0] a;
    logic [DATA-1:0] b;
    logic [DATA-1:0] d;
    logic            ovf;
  } vec_t;

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    vec_t vt [9];
    int cnt;
    logic [DATA:0] r;
    logic [NREQ-1:0] acc;

    vt[0] = '{0, 15'h0100, 15'h0180, 15'h0180, 1'b0};
    vt[1] = '{2, 15'h4200, 15'h0300, 15'h4600, 1'b0};
    vt[2] = '{1, 15'h1F00, 15'h0400, 15'h3FFF, 1'b1};
    vt[3] = '{3, 15'h4001, 15'h0001, 15'h0000, 1'b0};
    vt[4] = '{1, 15'h5F00, 15'h0400, 15'h7FFF, 1'b1};
    vt[5] = '{0, 15'h7FFF, 15'h7FFF, 15'h3FFF, 1'b1};
    vt[6] = '{2, 15'h0100, 15'h3FFF, 15'h3FFF, 1'b0};
    vt[7] = '{3, 15'h0181, 15'h0181, 15'h0243, 1'b0};
    vt[8] = '{1, 15'h4080, 15'h0001, 15'h0000, 1'b0};

    rst       = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      op_a[i] = '0;
      op_b[i] = '0;
    end
    tick();
    tick();
    rst = 1'b0;

    // Reset values
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'(0));
    chk("rst_mul_a", 32'(mul_a), 32'(0));
    chk("rst_mul_b", 32'(mul_b), 32'(0));
    chk("rst_mul_vld", 32'(mul_vld), 32'(0));
    chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
    chk("rst_rsp_id", 32'(rsp_id), 32'(0));
    chk("rst_rsp_data", 32'(rsp_data), 32'(0));
    chk("rst_rsp_ovf", 32'(rsp_ovf), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));

    // Table-driven single operations
    for (int v = 0; v < 9; v++) single_op(vt[v].id, vt[v].a, vt[v].b, vt[v].d, vt[v].ovf);

    // Fairness: all requesters held high, one grant and one response per cycle
    reset_dut();
    for (int i = 0; i < NREQ; i++) begin
      op_a[i] = DATA'((i + 1) * 32'h100);
      op_b[i] = (i % 2 == 1) ? 15'h4180 : 15'h0180;
    end
    rsp_ready = 1'b1;
    req_valid = '1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk("fair_grant", 32'(req_ready), 32'(1) << (k % NREQ));
      if (k >= 4) begin
        chk("fair_rsp_valid", 32'(rsp_valid), 32'(1));
        chk("fair_rsp_id", 32'(rsp_id), 32'((k - 4) % NREQ));
      end
      tick();
    end
    drain("fair_drain");

    // Back-pressure: exactly FIFO_DEPTH issues, head held, then resume
    tick();
    rsp_ready = 1'b0;
    req_valid = '1;
    cnt = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      cnt += $countones(req_ready & req_valid);
      tick();
    end
    chk("bp_handshakes", 32'(cnt), 32'(FIFO_DEPTH));
    r = ref_op(op_a[0], op_b[0]);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("bp_stall_ready", 32'(req_ready), 32'(0));
      chk("bp_hold_valid", 32'(rsp_valid), 32'(1));
      chk("bp_hold_id", 32'(rsp_id), 32'(0));
      chk("bp_hold_data", 32'(rsp_data), 32'(r[DATA-1:0]));
      tick();
    end
    rsp_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) tick();
      @(negedge clk);
      r = ref_op(op_a[k % NREQ], op_b[k % NREQ]);
      chk("bp_rsp_valid", 32'(rsp_valid), 32'(1));
      chk("bp_rsp_id", 32'(rsp_id), 32'(k % NREQ));
      chk("bp_rsp_data", 32'(rsp_data), 32'(r[DATA-1:0]));
      if (k == 0) chk("bp_no_issue_at_pop", 32'(req_ready), 32'(0));
      if (k == 1) chk("bp_resume", 32'(req_ready), 32'(1));
    end
    drain("bp_drain");

    // Mid-stream reset with 3 ops in flight and 2 queued
    reset_dut();
    rsp_ready = 1'b0;
    op_a[0]   = 15'h0100;
    op_b[0]   = 15'h0180;
    req_valid = 4'b0001;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("mr_issue", 32'(req_ready), 32'(1));
      tick();
    end
    req_valid = '0;
    rst = 1'b1;
    @(negedge clk);
    chk("mr_queued", 32'(rsp_valid), 32'(1));
    chk("mr_busy", 32'(busy), 32'(1));
    tick();
    rst = 1'b0;
    rsp_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("mr_no_rsp", 32'(rsp_valid), 32'(0));
      chk("mr_idle", 32'(busy), 32'(0));
      tick();
    end
    single_op(0, 15'h0100, 15'h0180, 15'h0180, 1'b0);

    // Randomised traffic checked by the reference model
    reset_dut();
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i] = 1'($urandom);
      op_a[i]      = rnd_op();
      op_b[i]      = rnd_op();
    end
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      acc = req_valid & req_ready;
      tick();
      if (c >= 300 && c < 400) rsp_ready = ($urandom_range(0, 9) < 2);
      else                     rsp_ready = ($urandom_range(0, 9) < 7);
      for (int i = 0; i < NREQ; i++) begin
        if (acc[i] || !req_valid[i]) begin
          req_valid[i] = ($urandom_range(0, 2) != 0);
          op_a[i]      = rnd_op();
          op_b[i]      = rnd_op();
        end
      end
    end
    drain("rand_drain");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
